// File: rtl/rr_step_sequencer.sv
// rr_step_sequencer: control-step generator for register-register ALU
// instructions. It fetches through PC/MAR/MDR, loads IR and decodes the
// ra/rb/rc fields into one-hot register selects. It also drives the ALU
// opcode and the Z/HI/LO strobes.
// Optional feature macro: RR_SEQ_MULDIV_EN adds a two-step LO/HI writeback
// for the multiply and divide opcodes. Without it those opcodes trap as illegal.
module rr_step_sequencer #(
  parameter int               DATA_W  = 32,
  parameter int               OPC_W   = 5,
  parameter int               REG_W   = 4,
  parameter int               NREG    = 16,
  parameter int               R0_ZERO = 1,
  parameter logic [OPC_W-1:0] MUL_OPC = 5'b01111,
  parameter logic [OPC_W-1:0] DIV_OPC = 5'b10000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] ir,
  output logic              PCout,
  output logic              incPC,
  output logic              PCin,
  output logic              MARin,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              ZLowOut,
  output logic              ZHighOut,
  output logic              HIin,
  output logic              LOin,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout,
  output logic [OPC_W-1:0]  opcode,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LOW_W = DATA_W - OPC_W - 3 * REG_W;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_ILL
`ifdef RR_SEQ_MULDIV_EN
    , S_T5_MD, S_T6
`endif
  } state_e;

  state_e state_q, state_d;
  logic   pc_first_q, pc_first_d;

  // IR fields: the opcode sits at the top, followed by ra, rb and rc.
  logic [OPC_W-1:0] ir_opc;
  logic [REG_W-1:0] ra, rb, rc;
  logic             unused_ir_low;

  assign ir_opc        = ir[DATA_W-1 -: OPC_W];
  assign ra            = ir[DATA_W-OPC_W-1 -: REG_W];
  assign rb            = ir[DATA_W-OPC_W-REG_W-1 -: REG_W];
  assign rc            = ir[DATA_W-OPC_W-2*REG_W-1 -: REG_W];
  assign unused_ir_low = ^ir[LOW_W-1:0];

  // A field value at or above NREG selects no register at all.
  function automatic logic [NREG-1:0] sel_onehot(input logic [REG_W-1:0] f);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (f == REG_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic opc_is_md;
  logic opc_illegal;
  assign opc_is_md = (ir_opc == MUL_OPC) || (ir_opc == DIV_OPC);
`ifdef RR_SEQ_MULDIV_EN
  assign opc_illegal = (ir_opc > DIV_OPC);
`else
  assign opc_illegal = (ir_opc > DIV_OPC) || opc_is_md;
`endif

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (clr) begin
      state_q    <= S_IDLE;
      pc_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_first_q <= pc_first_d;
    end
  end

  // Next-state logic. PCin is marked for only the first T1 cycle.
  always_comb begin
    state_d    = state_q;
    pc_first_d = (state_q == S_T0);
    case (state_q)
      S_IDLE:  if (start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_rdy) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = opc_illegal ? S_ILL : S_T4;
`ifdef RR_SEQ_MULDIV_EN
      S_T4:    state_d = opc_is_md ? S_T5_MD : S_T5;
      S_T5_MD: state_d = S_T6;
      S_T6:    state_d = S_IDLE;
`else
      S_T4:    state_d = S_T5;
`endif
      S_T5:    state_d = S_IDLE;
      S_ILL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode. Every strobe follows the current state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no latch is inferred.
    PCout    = 1'b0;
    incPC    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    opcode   = '0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        incPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        ZLowOut = 1'b1;
        PCin    = pc_first_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Rout = sel_onehot(rb);
        Yin  = 1'b1;
      end
      S_T4: begin
        Rout   = sel_onehot(rc);
        opcode = ir_opc;
        Zin    = 1'b1;
      end
      S_T5: begin
        ZLowOut = 1'b1;
        Rin     = sel_onehot(ra);
        // R0 is hard-wired to zero, so a load of R0 is dropped.
        if (R0_ZERO != 0) Rin[0] = 1'b0;
        done    = 1'b1;
      end
`ifdef RR_SEQ_MULDIV_EN
      S_T5_MD: begin
        ZLowOut = 1'b1;
        LOin    = 1'b1;
      end
      S_T6: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
`endif
      S_ILL:   err = 1'b1;
      default: ;
    endcase
  end

endmodule
